// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared definitions for the PC redirect controller: FSM state codes,
// request priority encoding and the default boot address.
package pc_redirect_ctrl_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_HOLD  = 2'd1;
  localparam state_t ST_FLUSH = 2'd2;

  // Larger code wins; PRIO_NONE means no request this cycle.
  typedef enum logic [1:0] {
    PRIO_NONE = 2'd0,
    PRIO_RET  = 2'd1,
    PRIO_BR   = 2'd2,
    PRIO_TRAP = 2'd3
  } prio_e;

endpackage

// File: rtl/pc_redirect_ctrl_prio_sel.sv
// Combinational request arbiter: picks trap > branch > return and reports the
// word-aligned target, its priority code and whether the raw target was misaligned.
module redir_prio_sel
  import pc_redirect_ctrl_pkg::*;
(
  input  logic        br_ctrl,
  input  logic [31:0] br_addr,
  input  logic        ret_ctrl,
  input  logic [31:0] ret_pc,
  input  logic        trap_req,
  input  logic [31:0] trap_vec,
  output logic [31:0] sel_addr,
  output prio_e       sel_prio,
  output logic        sel_mis
);

  logic [31:0] raw_addr;

  always_comb begin
    raw_addr = 32'h0;
    sel_prio = PRIO_NONE;
    if (trap_req) begin
      raw_addr = trap_vec;
      sel_prio = PRIO_TRAP;
    end else if (br_ctrl) begin
      raw_addr = br_addr;
      sel_prio = PRIO_BR;
    end else if (ret_ctrl) begin
      raw_addr = ret_pc;
      sel_prio = PRIO_RET;
    end
  end

  assign sel_addr = {raw_addr[31:2], 2'b00};
  assign sel_mis  = |raw_addr[1:0];

endmodule

// File: rtl/pc_redirect_ctrl.sv
// PC redirect controller: arbitrates redirect requests, holds one across a
// pipeline stall, issues a one-cycle redirect pulse and a fixed-length flush.
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_ctrl,
  input  logic [31:0] br_addr,
  input  logic        ret_ctrl,
  input  logic [31:0] ret_pc,
  input  logic        trap_req,
  input  logic [31:0] trap_vec,
  input  logic        pc_stall,
  output logic        redir_valid,
  output logic [31:0] redir_addr,
  output logic        flush,
  output logic        misalign,
  output logic        pending,
  output state_t      state_dbg
);

  localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};
  localparam logic        RESET_MIS   = |RESET_PC[1:0];
  localparam logic [2:0]  FLUSH_LOAD  = 3'(FLUSH_CYCLES - 1);

  state_t      state;
  logic        boot;
  logic [2:0]  cnt;
  logic [31:0] hold_addr;
  prio_e       hold_prio;
  logic        hold_mis;

  logic [31:0] sel_addr;
  prio_e       sel_prio;
  logic        sel_mis;

  logic        do_issue;
  logic        do_hold;
  logic [31:0] iss_addr;
  logic        iss_mis;

  redir_prio_sel u_prio_sel (
    .br_ctrl  (br_ctrl),
    .br_addr  (br_addr),
    .ret_ctrl (ret_ctrl),
    .ret_pc   (ret_pc),
    .trap_req (trap_req),
    .trap_vec (trap_vec),
    .sel_addr (sel_addr),
    .sel_prio (sel_prio),
    .sel_mis  (sel_mis)
  );

  // Decide per cycle whether to issue a redirect now or park one in the buffer.
  always_comb begin
    do_issue = 1'b0;
    do_hold  = 1'b0;
    iss_addr = sel_addr;
    iss_mis  = sel_mis;
    if (boot) begin
      do_issue = 1'b1;
      iss_addr = RESET_PC_AL;
      iss_mis  = RESET_MIS;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sel_prio != PRIO_NONE) begin
            do_hold  = pc_stall;
            do_issue = !pc_stall;
          end
        end
        ST_HOLD: begin
          if (!pc_stall) begin
            do_issue = 1'b1;
            // A strictly higher request arriving on the release cycle still wins.
            if (!(sel_prio > hold_prio)) begin
              iss_addr = hold_addr;
              iss_mis  = hold_mis;
            end
          end else if (sel_prio > hold_prio) begin
            do_hold = 1'b1;
          end
        end
        ST_FLUSH: begin
          // Branches and returns seen here are on the wrong path; only traps count.
          if (sel_prio == PRIO_TRAP) begin
            do_hold  = pc_stall;
            do_issue = !pc_stall;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      boot        <= 1'b1;
      redir_valid <= 1'b0;
      redir_addr  <= RESET_PC_AL;
      flush       <= 1'b0;
      misalign    <= 1'b0;
      pending     <= 1'b0;
      cnt         <= 3'd0;
      hold_addr   <= 32'h0;
      hold_prio   <= PRIO_NONE;
      hold_mis    <= 1'b0;
    end else begin
      boot        <= 1'b0;
      redir_valid <= 1'b0;
      misalign    <= 1'b0;
      if (do_issue) begin
        redir_valid <= 1'b1;
        redir_addr  <= iss_addr;
        misalign    <= iss_mis;
        flush       <= 1'b1;
        cnt         <= FLUSH_LOAD;
        pending     <= 1'b0;
        state       <= ST_FLUSH;
      end else if (do_hold) begin
        hold_addr <= sel_addr;
        hold_prio <= sel_prio;
        hold_mis  <= sel_mis;
        pending   <= 1'b1;
        flush     <= 1'b0;
        state     <= ST_HOLD;
      end else if (state == ST_FLUSH) begin
        if (cnt == 3'd0) begin
          flush <= 1'b0;
          state <= ST_IDLE;
        end else begin
          cnt <= cnt - 3'd1;
        end
      end else if (state != ST_IDLE && state != ST_HOLD) begin
        state <= ST_IDLE;
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed table-driven bench for pc_redirect_ctrl plus hand sequences for
// reset-in-HOLD and a second instance with a non-zero boot address and longer flush.
module tb_pc_redirect_ctrl;
  import pc_redirect_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        br_ctrl;
  logic [31:0] br_addr;
  logic        ret_ctrl;
  logic [31:0] ret_pc;
  logic        trap_req;
  logic [31:0] trap_vec;
  logic        pc_stall;

  logic        redir_valid, flush, misalign, pending;
  logic [31:0] redir_addr;
  state_t      state_dbg;

  logic        redir_valid2, flush2, misalign2, pending2;
  logic [31:0] redir_addr2;
  state_t      state_dbg2;

  int n_cmp;
  int n_err;

  pc_redirect_ctrl dut (
    .clk(clk), .rst(rst),
    .br_ctrl(br_ctrl), .br_addr(br_addr),
    .ret_ctrl(ret_ctrl), .ret_pc(ret_pc),
    .trap_req(trap_req), .trap_vec(trap_vec),
    .pc_stall(pc_stall),
    .redir_valid(redir_valid), .redir_addr(redir_addr),
    .flush(flush), .misalign(misalign), .pending(pending),
    .state_dbg(state_dbg)
  );

  pc_redirect_ctrl #(.RESET_PC(32'h0000_1000), .FLUSH_CYCLES(3)) dut2 (
    .clk(clk), .rst(rst),
    .br_ctrl(br_ctrl), .br_addr(br_addr),
    .ret_ctrl(ret_ctrl), .ret_pc(ret_pc),
    .trap_req(trap_req), .trap_vec(trap_vec),
    .pc_stall(pc_stall),
    .redir_valid(redir_valid2), .redir_addr(redir_addr2),
    .flush(flush2), .misalign(misalign2), .pending(pending2),
    .state_dbg(state_dbg2)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        br;
    logic [31:0] ba;
    logic        ret;
    logic [31:0] rp;
    logic        trap;
    logic [31:0] tv;
    logic        stall;
    logic        e_valid;
    logic [31:0] e_addr;
    logic        e_flush;
    logic        e_mis;
    logic        e_pend;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic br, logic [31:0] ba, logic ret, logic [31:0] rp,
                              logic trap, logic [31:0] tv, logic stall,
                              logic ev, logic [31:0] ea, logic ef, logic em, logic ep);
    vec_t v;
    v.br = br; v.ba = ba; v.ret = ret; v.rp = rp; v.trap = trap; v.tv = tv;
    v.stall = stall; v.e_valid = ev; v.e_addr = ea; v.e_flush = ef;
    v.e_mis = em; v.e_pend = ep;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic br, input logic [31:0] ba, input logic ret,
                       input logic [31:0] rp, input logic trap, input logic [31:0] tv,
                       input logic stall);
    br_ctrl = br; br_addr = ba; ret_ctrl = ret; ret_pc = rp;
    trap_req = trap; trap_vec = tv; pc_stall = stall;
  endtask

  task automatic drive_idle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  logic        exp2_flush[4];
  int          n_redir;
  logic [31:0] first_addr;
  int          first_cyc;

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp2_flush = '{1'b1, 1'b1, 1'b1, 1'b0};

    // One row per cycle: inputs before the edge, expected outputs after it.
    vecs.push_back(mk(0, 0,      0, 0,      0, 0,     0,  1, 32'h0,   1, 0, 0)); // boot pulse
    vecs.push_back(mk(0, 0,      0, 0,      0, 0,     0,  0, 32'h0,   1, 0, 0));
    vecs.push_back(mk(0, 0,      0, 0,      0, 0,     0,  0, 32'h0,   0, 0, 0));
    vecs.push_back(mk(1, 'h100,  0, 0,      0, 0,     0,  1, 32'h100, 1, 0, 0)); // plain branch
    vecs.push_back(mk(0, 0,      0, 0,      0, 0,     0,  0, 32'h100, 1, 0, 0));
    vecs.push_back(mk(0, 0,      0, 0,      0, 0,     0,  0, 32'h100, 0, 0, 0));
    vecs.push_back(mk(1, 'h200,  1, 'h300,  1, 'h80,  0,  1, 32'h80,  1, 0, 0)); // all three
    vecs.push_back(mk(0, 0,      0, 0,      0, 0,     0,  0, 32'h80,  1, 0, 0));
    vecs.push_back(mk(0, 0,      0, 0,      0, 0,     0,  0, 32'h80,  0, 0, 0));
    vecs.push_back(mk(1, 'h102,  0, 0,      0, 0,     0,  1, 32'h100, 1, 1, 0)); // misaligned
    vecs.push_back(mk(1, 'h200,  0, 0,      0, 0,     0,  0, 32'h100, 1, 0, 0)); // br in FLUSH
    vecs.push_back(mk(0, 0,      1, 'h300,  0, 0,     0,  0, 32'h100, 0, 0, 0)); // ret in FLUSH
    vecs.push_back(mk(0, 0,      1, 'h44,   0, 0,     0,  1, 32'h44,  1, 0, 0)); // return
    vecs.push_back(mk(0, 0,      0, 0,      1, 'h88,  0,  1, 32'h88,  1, 0, 0)); // trap in FLUSH
    vecs.push_back(mk(0, 0,      0, 0,      0, 0,     0,  0, 32'h88,  1, 0, 0));
    vecs.push_back(mk(0, 0,      0, 0,      0, 0,     0,  0, 32'h88,  0, 0, 0));
    vecs.push_back(mk(1, 'h40,   0, 0,      0, 0,     1,  0, 32'h88,  0, 0, 1)); // br stalled
    vecs.push_back(mk(0, 0,      0, 0,      0, 0,     1,  0, 32'h88,  0, 0, 1));
    vecs.push_back(mk(0, 0,      0, 0,      1, 'h80,  1,  0, 32'h88,  0, 0, 1)); // trap overwrites
    vecs.push_back(mk(0, 0,      1, 'h10,   0, 0,     1,  0, 32'h88,  0, 0, 1)); // ret dropped
    vecs.push_back(mk(0, 0,      0, 0,      0, 0,     0,  1, 32'h80,  1, 0, 0)); // release
    vecs.push_back(mk(0, 0,      0, 0,      0, 0,     0,  0, 32'h80,  1, 0, 0));
    vecs.push_back(mk(0, 0,      0, 0,      0, 0,     0,  0, 32'h80,  0, 0, 0));
    vecs.push_back(mk(1, 'h500,  0, 0,      0, 0,     1,  0, 32'h80,  0, 0, 1));
    vecs.push_back(mk(1, 'h600,  0, 0,      0, 0,     1,  0, 32'h80,  0, 0, 1)); // equal prio dropped
    vecs.push_back(mk(0, 0,      0, 0,      0, 0,     0,  1, 32'h500, 1, 0, 0));
    vecs.push_back(mk(0, 0,      0, 0,      0, 0,     0,  0, 32'h500, 1, 0, 0));
    vecs.push_back(mk(0, 0,      0, 0,      0, 0,     0,  0, 32'h500, 0, 0, 0));
    vecs.push_back(mk(1, 'h20,   0, 0,      0, 0,     0,  1, 32'h20,  1, 0, 0));
    vecs.push_back(mk(0, 0,      0, 0,      1, 'h90,  1,  0, 32'h20,  0, 0, 1)); // trap in FLUSH, stalled
    vecs.push_back(mk(0, 0,      0, 0,      0, 0,     0,  1, 32'h90,  1, 0, 0));
    vecs.push_back(mk(0, 0,      0, 0,      0, 0,     0,  0, 32'h90,  1, 0, 0));
    vecs.push_back(mk(0, 0,      0, 0,      0, 0,     0,  0, 32'h90,  0, 0, 0));

    // Reset state
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid",   32'(redir_valid), 32'h0);
    check("rst.addr",    redir_addr,       32'h0);
    check("rst.flush",   32'(flush),       32'h0);
    check("rst.mis",     32'(misalign),    32'h0);
    check("rst.pending", 32'(pending),     32'h0);
    check("rst.state",   32'(state_dbg),   32'(ST_IDLE));
    check("rst.addr2",   redir_addr2,      32'h1000);
    check("rst.state2",  32'(state_dbg2),  32'(ST_IDLE));

    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].br, vecs[i].ba, vecs[i].ret, vecs[i].rp,
            vecs[i].trap, vecs[i].tv, vecs[i].stall);
      @(posedge clk);
      #1;
      check($sformatf("v%0d.valid", i),   32'(redir_valid), 32'(vecs[i].e_valid));
      check($sformatf("v%0d.addr", i),    redir_addr,       vecs[i].e_addr);
      check($sformatf("v%0d.flush", i),   32'(flush),       32'(vecs[i].e_flush));
      check($sformatf("v%0d.mis", i),     32'(misalign),    32'(vecs[i].e_mis));
      check($sformatf("v%0d.pending", i), 32'(pending),     32'(vecs[i].e_pend));
      if (i < 4) begin
        check($sformatf("v%0d.flush2", i), 32'(flush2), 32'(exp2_flush[i]));
        check($sformatf("v%0d.valid2", i), 32'(redir_valid2), (i == 0) ? 32'h1 : 32'h0);
      end
      if (i == 0) begin
        check("v0.addr2",    redir_addr2,     32'h1000);
        check("v0.mis2",     32'(misalign2),  32'h0);
        check("v0.pending2", 32'(pending2),   32'h0);
      end
      @(negedge clk);
    end

    // Reset while a redirect is held: buffer discarded, only the boot redirect follows.
    drive(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    check("hold.pending", 32'(pending), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_hold.pending", 32'(pending),     32'h0);
    check("rst_hold.valid",   32'(redir_valid), 32'h0);
    check("rst_hold.flush",   32'(flush),       32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    n_redir    = 0;
    first_addr = 32'hFFFF_FFFF;
    first_cyc  = -1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (redir_valid) begin
        if (n_redir == 0) begin
          first_addr = redir_addr;
          first_cyc  = c;
        end
        n_redir++;
      end
    end
    check("rst_hold.redir_count", 32'(n_redir),   32'h1);
    check("rst_hold.redir_addr",  first_addr,     32'h0);
    check("rst_hold.redir_cycle", 32'(first_cyc), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, legal 1..7: cycles of flush after each redirect.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port br_ctrl  in  1  branch/jump taken request.
REQ-006 SHALL have port br_addr  in  32  branch target.
REQ-007 SHALL have port ret_ctrl  in  1  return-from-trap request.
REQ-008 SHALL have port ret_pc  in  32  return target.
REQ-009 SHALL have port trap_req  in  1  trap/interrupt entry request.
REQ-010 SHALL have port trap_vec  in  32  trap handler address.
REQ-011 SHALL have port pc_stall  in  1  hazard stall; PC must not advance.
REQ-012 SHALL have port redir_valid  out  1  one-cycle pulse: PC loads redir_addr.
REQ-013 SHALL have port redir_addr  out  32  selected target, bits [1:0] forced to 0.
REQ-014 SHALL have port flush  out  1  kill younger instructions in IF/ID.
REQ-015 SHALL have port misalign  out  1  one-cycle pulse: the issued target had addr[1:0] != 0.
REQ-016 SHALL have port pending  out  1  a redirect is held awaiting stall release.

Function
REQ-017 SHALL select among simultaneous requests with priority trap_req > br_ctrl > ret_ctrl; lower-priority requests in the same cycle are dropped.
REQ-018 SHALL use FSM states IDLE, HOLD and FLUSH.
REQ-019 IDLE, request present and pc_stall=0: SHALL register the target, pulse redir_valid the next cycle, then enter FLUSH.
REQ-020 IDLE, request present and pc_stall=1: SHALL latch the target into a one-entry hold buffer, enter HOLD and assert pending.
REQ-021 HOLD, new request of strictly higher priority than the held one: SHALL overwrite the buffer; equal or lower priority SHALL be dropped.
REQ-022 HOLD, pc_stall falls to 0: SHALL pulse redir_valid with the held target in the following cycle, clear pending and enter FLUSH.
REQ-023 Latency rule: redir_valid SHALL follow the request, or the stall release, by exactly one cycle.
REQ-024 FLUSH: SHALL assert flush for FLUSH_CYCLES cycles starting in the redir_valid cycle, using a 3-bit down-counter, then return to IDLE.
REQ-025 FLUSH, trap_req arrives: SHALL be accepted (same handling as IDLE) and restart the counter; br_ctrl and ret_ctrl arriving in FLUSH SHALL be ignored as wrong-path.
REQ-026 misalign SHALL pulse in the same cycle as redir_valid when the original target had bits [1:0] != 0.
REQ-027 redir_valid SHALL never be asserted for two consecutive cycles, except for a trap accepted in FLUSH.
REQ-028 The first cycle after reset release SHALL pulse redir_valid with redir_addr=RESET_PC and assert flush.

Reset
REQ-029 Assertion of rst SHALL asynchronously set: FSM=IDLE, redir_valid=0, redir_addr=RESET_PC, flush=0, misalign=0, pending=0, counter=0, buffer cleared.
REQ-030 rst asserted mid-HOLD or mid-FLUSH SHALL discard the held target with no redir_valid issued.
REQ-031 A boot flag set by reset SHALL trigger the REQ-028 pulse and then clear.

Structure
REQ-032 The FSM state enum, the request-priority encoding and the default RESET_PC SHALL live in the shared core package.
REQ-033 The priority selection (three requests to target, priority code and misalign flag) SHALL be one combinational sub-module, redir_prio_sel; the FSM, buffer and counter stay in the top.

Verification
REQ-034 Reset release with RESET_PC=0 -> next cycle: redir_valid=1, redir_addr=0, flush=1 for 2 cycles.
REQ-035 br_ctrl=1, br_addr=0x100, pc_stall=0 in cycle N -> redir_valid=1, redir_addr=0x100 in N+1; flush=1 in N+1 and N+2.
REQ-036 trap_req with trap_vec=0x80, br_ctrl with br_addr=0x200 and ret_ctrl all in the same cycle -> a single redir_valid with redir_addr=0x80.
REQ-037 br_ctrl to 0x40 under pc_stall=1, then trap to 0x80 while still stalled, stall drops at cycle M -> pending=1 throughout the stall; one redir_valid at M+1 with redir_addr=0x80.
REQ-038 br_addr=0x102 -> redir_addr=0x100, misalign pulses with redir_valid; a second br_ctrl during FLUSH -> no redir_valid.
REQ-039 rst asserted while in HOLD -> pending=0 immediately; after release the only redirect issued is to RESET_PC.
